// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: byte/half/word load-store initiator for a word-addressed memory port (optional misalignment trap: DMAU_MISALIGN_TRAP_EN)
module data_mem_access_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH+1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             err,
  output logic [WIDTH-1:0] mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [31:0]      mem_data_out,
  input  logic             mem_stall
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;
  state_t state, state_d;
  logic wr_q, sgn_q, accept, misalign, trap, capture;
  logic [1:0] size_q, lane_q, lane_in;
  logic [31:0] wdata_q, shifted, ext, lane_mask, merged;
  logic [31:0] rdata_d, mem_data_in_d;
  logic [WIDTH-1:0] mem_address_d;
  logic done_d, err_d, mem_read_d, mem_write_d;
  assign req_ready = state == IDLE;
  assign accept = req_valid & req_ready;
  assign capture = state == READ && !mem_stall;
  assign misalign = req_size[1] ? |req_addr[1:0] : req_size[0] & req_addr[0];
`ifdef DMAU_MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  assign trap = 1'b0;
`endif
  // low address bits a lane selection may use: halves align to addr[1], words to lane 0
  assign lane_in = req_size[1] ? 2'b00 : req_size[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
  // lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    shifted = mem_data_out >> {lane_q, 3'b000};
    ext = size_q[1] ? mem_data_out :
          size_q[0] ? {{16{sgn_q & shifted[15]}}, shifted[15:0]} :
                      {{24{sgn_q & shifted[7]}}, shifted[7:0]};
    lane_mask = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
    merged = (mem_data_out & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);
  end
  // state and registered outputs; request fields latched on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      done <= done_d;
      err <= err_d;
      rdata <= rdata_d;
      mem_read <= mem_read_d;
      mem_write <= mem_write_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
      if (accept) begin
        wr_q <= req_write;
        sgn_q <= req_signed;
        size_q <= req_size;
        lane_q <= lane_in;
        wdata_q <= req_wdata;
      end
    end
  end
  // next state: word stores skip the read, sub-word stores read then merge
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = trap ? DONE : (req_write && req_size[1]) ? WRITE : READ;
      READ:    if (!mem_stall) state_d = wr_q ? MERGE : DONE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // next values of the registered outputs, derived from the next state
  always_comb begin
    mem_read_d = state_d == READ;
    mem_write_d = state_d == WRITE;
    done_d = state_d == DONE;
    err_d = accept && trap;
    rdata_d = (capture && !wr_q) ? ext : 32'd0;
    mem_address_d = accept ? req_addr[WIDTH+1:2] : mem_address;
    mem_data_in_d = (accept && req_write && req_size[1]) ? req_wdata :
                    (capture && wr_q) ? merged : mem_data_in;
  end
endmodule
